led7seg_capture: RTL and testbench
==================================

// Module: led7seg_capture
// PURPOSE
//  Receive side of the multiplexed 7-segment display bus (LED[7:0] segments, SA[3:0] digit select).
//  Samples the bus, waits for a stable pattern, decodes the segment pattern back to a 4-bit hex value per digit.
//  Captures all four digit slots and flags an undecodable pattern.
//  Used as an on-chip monitor/loopback checker behind the 7-seg drivers and as a capture block on test boards.
// PARAMETERS
//  STABLE_CYC  4      consecutive identical samples required before a pattern is accepted (>=1)
//  TIMEOUT     65535  cycles without a refresh of a digit before its VLD bit clears (>=STABLE_CYC+2)
// PORTS
//  CLK    in   1   system clock
//  RST_N  in   1   synchronous reset, active-low
//  LED    in   8   segment bus, active-low: [0]=a [1]=b [2]=c [3]=d [4]=e [5]=f [6]=g [7]=dp
//  SA     in   4   digit select, active-low; exactly one bit 0 = that digit driven; 1/Z = not driven
//  DIG    out  16  decoded values, DIG[4k+3:4k] = digit k
//  VLD    out  4   digit k holds a decoded value refreshed within TIMEOUT cycles
//  BLANK  out  4   last accepted pattern for digit k was all segments off (LED[6:0]=7'h7F)
//  DP     out  4   decimal point of digit k lit in last accepted pattern (LED[7]==0)
//  ERR    out  1   sticky: a non-hex, non-blank pattern was accepted; cleared only by reset
//  FRAME  out  1   1-cycle pulse: all four digits accepted at least once since previous FRAME/reset
// BEHAVIOUR
//  Reset (RST_N=0 at CLK edge): DIG=0, VLD=0, BLANK=0, DP=0, ERR=0, FRAME=0, FSM=IDLE, all counters 0.
//  Input path: LED and SA pass a 2-flop synchroniser; Z/X on SA is resolved by the synchroniser, only a clean 0 selects.
//  Sample S = {SA_sync, LED_sync}; P = previous-cycle S. Valid select: SA_sync has exactly one 0 bit.
//  FSM:
//   IDLE   : select invalid. Valid select -> SETTLE, cnt=1.
//   SETTLE : S==P -> cnt++; S!=P -> cnt=1 (stay SETTLE if select valid, else IDLE).
//            When cnt reaches STABLE_CYC -> ACCEPT action this cycle, go HELD.
//   HELD   : pattern already written; no rewrite while S==P. S!=P -> SETTLE (cnt=1) or IDLE.
//  ACCEPT (one cycle, k = index of 0 bit in SA_sync): seg = ~LED_sync[6:0] (active-high gfedcba):
//   3F->0 06->1 5B->2 4F->3 66->4 6D->5 7D->6 07->7 7F->8 6F->9 77->A 7C->b 39->C 5E->d 79->E 71->F.
//   Hex match: DIG slot k=value, BLANK[k]=0, VLD[k]=1. seg=00: BLANK[k]=1, VLD[k]=1, DIG slot k unchanged.
//   Other: ERR=1, VLD[k]=0, DIG/BLANK slot k unchanged. DP[k]=~LED_sync[7] in all three cases.
//   Accept also reloads digit k's timeout counter and sets seen[k].
//  Latency: input change to updated outputs = 2 (sync) + STABLE_CYC cycles; outputs registered.
//  Timeout: per-digit counter increments each cycle, saturates at TIMEOUT; reaching TIMEOUT clears VLD[k] only.
//  FRAME: cycle after an accept makes seen==4'hF: FRAME=1, seen cleared; accept in that same cycle counts toward next frame.
//  Re-accept of identical pattern only after the bus changes and returns (HELD blocks repeats).
//  Mid-operation reset: everything returns to reset values next edge; partial SETTLE count discarded.
//  Two or more SA bits low = invalid select (treated as IDLE), never an ERR.
// TESTING
//  Reset, SA=4'b1110, LED=8'hC0 held 10 cycles -> DIG[3:0]=0, VLD=0001, DP=0, ERR=0 at cycle 2+STABLE_CYC.
//  Scan digits 0..3 with 7-seg codes of 1,2,3,A (LED=F9,A4,B0,88), 8 cycles each -> DIG=16'hA321, VLD=1111, one FRAME pulse.
//  Glitch: pattern held only STABLE_CYC-1 cycles between stable ones -> no update, DIG unchanged.
//  SA=1101, LED=8'hFF -> BLANK[1]=1, VLD[1]=1; LED=8'h7F -> DP[1]=1; LED=8'hF7 (segment d only) -> ERR=1, VLD[1]=0.
//  SA=1100 or 1111 for 100 cycles -> no accept, no ERR; stop refreshing digit 2 for TIMEOUT cycles -> VLD[2]=0.
//  RST_N low for one cycle mid-SETTLE -> all outputs zero next cycle; capture resumes normally after release.

Source files
------------

// File: rtl/led7seg_capture.sv
// Receive side of a multiplexed, active-low 7-segment display bus.
// Synchronises LED/SA, waits for a pattern to be stable, decodes it back to
// a hex nibble per digit slot, tracks freshness per digit and flags
// undecodable patterns. state_dbg exposes the acceptance FSM.
module led7seg_capture #(
  parameter int STABLE_CYC = 4,
  parameter int TIMEOUT    = 65535
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [7:0]  LED,
  input  logic [3:0]  SA,
  output logic [15:0] DIG,
  output logic [3:0]  VLD,
  output logic [3:0]  BLANK,
  output logic [3:0]  DP,
  output logic        ERR,
  output logic        FRAME,
  output logic [1:0]  state_dbg
);

  localparam int CW = $clog2(STABLE_CYC + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] STABLE_MAX = CW'(STABLE_CYC);
  localparam logic [TW-1:0] TO_MAX     = TW'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HELD   = 2'd2
  } state_t;

  // Input synchroniser and previous-sample register
  logic [7:0]  led_s1_q, led_s1_d, led_s2_q, led_s2_d;
  logic [3:0]  sa_s1_q, sa_s1_d, sa_s2_q, sa_s2_d;
  logic [11:0] prev_q, prev_d;

  // FSM
  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           accept;

  // Captured outputs and bookkeeping
  logic [15:0]         dig_q, dig_d;
  logic [3:0]          vld_q, vld_d;
  logic [3:0]          blank_q, blank_d;
  logic [3:0]          dp_q, dp_d;
  logic                err_q, err_d;
  logic                frame_q, frame_d;
  logic [3:0]          seen_q, seen_d;
  logic [3:0][TW-1:0]  to_cnt_q, to_cnt_d;

  // Current sample decoding
  logic [11:0] s_cur;
  logic [3:0]  sel_n;
  logic        sel_valid;
  logic        same;
  logic [1:0]  dig_idx;
  logic [6:0]  seg;
  logic [4:0]  dec;

  // Map an active-high gfedcba pattern to {hit, value}
  function automatic logic [4:0] decode_seg(input logic [6:0] s);
    logic [4:0] r;
    case (s)
      7'h3F:   r = {1'b1, 4'h0};
      7'h06:   r = {1'b1, 4'h1};
      7'h5B:   r = {1'b1, 4'h2};
      7'h4F:   r = {1'b1, 4'h3};
      7'h66:   r = {1'b1, 4'h4};
      7'h6D:   r = {1'b1, 4'h5};
      7'h7D:   r = {1'b1, 4'h6};
      7'h07:   r = {1'b1, 4'h7};
      7'h7F:   r = {1'b1, 4'h8};
      7'h6F:   r = {1'b1, 4'h9};
      7'h77:   r = {1'b1, 4'hA};
      7'h7C:   r = {1'b1, 4'hB};
      7'h39:   r = {1'b1, 4'hC};
      7'h5E:   r = {1'b1, 4'hD};
      7'h79:   r = {1'b1, 4'hE};
      7'h71:   r = {1'b1, 4'hF};
      default: r = 5'b0_0000;
    endcase
    return r;
  endfunction

  // Sample classification: select validity, stability and target digit
  always_comb begin
    led_s1_d  = LED;
    led_s2_d  = led_s1_q;
    sa_s1_d   = SA;
    sa_s2_d   = sa_s1_q;
    s_cur     = {sa_s2_q, led_s2_q};
    prev_d    = s_cur;
    sel_n     = ~sa_s2_q;
    sel_valid = (sel_n != 4'd0) && ((sel_n & (sel_n - 4'd1)) == 4'd0);
    same      = (s_cur == prev_q);
    seg       = ~led_s2_q[6:0];
    dec       = decode_seg(seg);
    dig_idx   = 2'd0;
    case (sel_n)
      4'b0010: dig_idx = 2'd1;
      4'b0100: dig_idx = 2'd2;
      4'b1000: dig_idx = 2'd3;
      default: dig_idx = 2'd0;
    endcase
  end

  // Next-state logic: count identical samples, accept once, then hold off
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (sel_valid) begin
          state_d = SETTLE;
          cnt_d   = CW'(1);
        end
      end
      SETTLE: begin
        if (same) begin
          if (cnt_q < STABLE_MAX) cnt_d = cnt_q + CW'(1);
        end else if (sel_valid) begin
          cnt_d = CW'(1);
        end else begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      HELD: begin
        if (!same) begin
          if (sel_valid) begin
            state_d = SETTLE;
            cnt_d   = CW'(1);
          end else begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    // Stable long enough: write the pattern this cycle and block repeats
    if (state_d == SETTLE && cnt_d == STABLE_MAX) begin
      accept  = 1'b1;
      state_d = HELD;
      cnt_d   = '0;
    end
  end

  // Capture datapath: decode on accept, per-digit timeout, frame tracking
  always_comb begin
    dig_d    = dig_q;
    vld_d    = vld_q;
    blank_d  = blank_q;
    dp_d     = dp_q;
    err_d    = err_q;
    to_cnt_d = to_cnt_q;
    frame_d  = (seen_q == 4'hF);
    seen_d   = frame_d ? 4'h0 : seen_q;
    for (int k = 0; k < 4; k++) begin
      if (to_cnt_q[k] != TO_MAX) begin
        to_cnt_d[k] = to_cnt_q[k] + TW'(1);
        if (to_cnt_d[k] == TO_MAX) vld_d[k] = 1'b0;
      end
    end
    if (accept) begin
      dp_d[dig_idx]     = ~led_s2_q[7];
      to_cnt_d[dig_idx] = '0;
      seen_d[dig_idx]   = 1'b1;
      if (dec[4]) begin
        dig_d[{dig_idx, 2'b00} +: 4] = dec[3:0];
        blank_d[dig_idx]             = 1'b0;
        vld_d[dig_idx]               = 1'b1;
      end else if (seg == 7'h00) begin
        blank_d[dig_idx] = 1'b1;
        vld_d[dig_idx]   = 1'b1;
      end else begin
        err_d          = 1'b1;
        vld_d[dig_idx] = 1'b0;
      end
    end
  end

  // Register bank with synchronous active-low reset
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      led_s1_q <= '0;
      led_s2_q <= '0;
      sa_s1_q  <= '0;
      sa_s2_q  <= '0;
      prev_q   <= '0;
      state_q  <= IDLE;
      cnt_q    <= '0;
      dig_q    <= '0;
      vld_q    <= '0;
      blank_q  <= '0;
      dp_q     <= '0;
      err_q    <= 1'b0;
      frame_q  <= 1'b0;
      seen_q   <= '0;
      to_cnt_q <= '0;
    end else begin
      led_s1_q <= led_s1_d;
      led_s2_q <= led_s2_d;
      sa_s1_q  <= sa_s1_d;
      sa_s2_q  <= sa_s2_d;
      prev_q   <= prev_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      dig_q    <= dig_d;
      vld_q    <= vld_d;
      blank_q  <= blank_d;
      dp_q     <= dp_d;
      err_q    <= err_d;
      frame_q  <= frame_d;
      seen_q   <= seen_d;
      to_cnt_q <= to_cnt_d;
    end
  end

  assign DIG       = dig_q;
  assign VLD       = vld_q;
  assign BLANK     = blank_q;
  assign DP        = dp_q;
  assign ERR       = err_q;
  assign FRAME     = frame_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_led7seg_capture.sv
// Directed bench for led7seg_capture (STABLE_CYC=4, TIMEOUT=400).
module tb_led7seg_capture;

  localparam int STABLE = 4;
  localparam int TO     = 400;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic [7:0]  LED;
  logic [3:0]  SA;
  logic [15:0] DIG;
  logic [3:0]  VLD, BLANK, DP;
  logic        ERR, FRAME;
  logic [1:0]  state_dbg;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] exp_q[$];
  logic [3:0]  scan_sa[4]  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
  logic [7:0]  scan_led[4] = '{8'hF9, 8'hA4, 8'hB0, 8'h88};

  // Clock and DUT
  always #5 CLK = ~CLK;

  led7seg_capture #(.STABLE_CYC(STABLE), .TIMEOUT(TO)) dut (
    .CLK(CLK), .RST_N(RST_N), .LED(LED), .SA(SA), .DIG(DIG), .VLD(VLD),
    .BLANK(BLANK), .DP(DP), .ERR(ERR), .FRAME(FRAME), .state_dbg(state_dbg)
  );

  // Advance n rising edges, then settle 1 time unit past the edge
  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST_N = 1'b0;
    SA    = 4'hF;
    LED   = 8'hFF;
    tick(2);
    RST_N = 1'b1;
    tick(1);
  endtask

  task automatic test_reset();
    RST_N = 1'b0;
    SA    = 4'b1110;
    LED   = 8'h00;
    tick(3);
    n_checks++;
    if ({DIG, VLD, BLANK, DP, ERR, FRAME, state_dbg} !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_outputs got=%h exp=%h", {DIG, VLD, BLANK, DP, ERR, FRAME, state_dbg}, 32'h0);
    end
    RST_N = 1'b1;
  endtask

  // Single digit held: update lands exactly 2+STABLE edges after the change
  task automatic test_latency();
    do_reset();
    SA  = 4'b1110;
    LED = 8'hC0;
    tick(2 + STABLE - 1);
    n_checks++;
    if (VLD !== 4'b0000) begin
      n_fail++;
      $display("FAIL latency_early_vld got=%b exp=%b", VLD, 4'b0000);
    end
    tick(1);
    n_checks++;
    if ({DIG, VLD, BLANK, DP, ERR} !== {16'h0000, 4'b0001, 4'b0000, 4'b0000, 1'b0}) begin
      n_fail++;
      $display("FAIL latency_capture got=%h/%b/%b/%b/%b exp=0000/0001/0000/0000/0", DIG, VLD, BLANK, DP, ERR);
    end
    n_checks++;
    if (state_dbg !== 2'd2) begin
      n_fail++;
      $display("FAIL latency_state_held got=%0d exp=%0d", state_dbg, 2);
    end
    tick(4);
    n_checks++;
    if (VLD !== 4'b0001 || state_dbg !== 2'd2) begin
      n_fail++;
      $display("FAIL latency_hold got=%b/%0d exp=0001/2", VLD, state_dbg);
    end
  endtask

  // Scan all four digits, one FRAME pulse expected
  task automatic test_scan();
    int fc;
    logic [15:0] exp_dig;
    do_reset();
    fc = 0;
    exp_q = {16'h0001, 16'h0021, 16'h0321, 16'hA321};
    for (int d = 0; d < 4; d++) begin
      SA  = scan_sa[d];
      LED = scan_led[d];
      for (int c = 0; c < 8; c++) begin
        tick(1);
        if (FRAME) fc++;
      end
      exp_dig = exp_q.pop_front();
      n_checks++;
      if (DIG !== exp_dig) begin
        n_fail++;
        $display("FAIL scan_dig_%0d got=%h exp=%h", d, DIG, exp_dig);
      end
    end
    for (int c = 0; c < 6; c++) begin
      tick(1);
      if (FRAME) fc++;
    end
    n_checks++;
    if (VLD !== 4'hF || DP !== 4'h0 || ERR !== 1'b0) begin
      n_fail++;
      $display("FAIL scan_flags got=%b/%b/%b exp=1111/0000/0", VLD, DP, ERR);
    end
    n_checks++;
    if (fc !== 1) begin
      n_fail++;
      $display("FAIL scan_frame_count got=%0d exp=%0d", fc, 1);
    end
  endtask

  // Short glitch is filtered; a stable change of the same length+1 is taken
  task automatic test_glitch();
    int bad;
    bad = 0;
    SA  = 4'b0111;
    LED = 8'hF9;
    tick(STABLE - 1);
    if (DIG[15:12] !== 4'hA) bad++;
    LED = 8'h88;
    for (int c = 0; c < 10; c++) begin
      tick(1);
      if (DIG[15:12] !== 4'hA) bad++;
    end
    n_checks++;
    if (bad !== 0 || DIG !== 16'hA321) begin
      n_fail++;
      $display("FAIL glitch_filtered got=%h bad_cycles=%0d exp=a321", DIG, bad);
    end
    LED = 8'hF9;
    tick(8);
    n_checks++;
    if (DIG !== 16'h1321) begin
      n_fail++;
      $display("FAIL glitch_stable_taken got=%h exp=%h", DIG, 16'h1321);
    end
  endtask

  // Blank, decimal point and undecodable patterns on digit 1
  task automatic test_blank_dp_err();
    do_reset();
    SA  = 4'b1101;
    LED = 8'hA4;
    tick(8);
    LED = 8'hFF;
    tick(8);
    n_checks++;
    if ({DIG, VLD, BLANK, DP, ERR} !== {16'h0020, 4'b0010, 4'b0010, 4'b0000, 1'b0}) begin
      n_fail++;
      $display("FAIL blank got=%h/%b/%b/%b/%b exp=0020/0010/0010/0000/0", DIG, VLD, BLANK, DP, ERR);
    end
    LED = 8'h7F;
    tick(8);
    n_checks++;
    if (DP !== 4'b0010 || BLANK !== 4'b0010 || VLD !== 4'b0010) begin
      n_fail++;
      $display("FAIL dp_lit got=%b/%b/%b exp=0010/0010/0010", DP, BLANK, VLD);
    end
    LED = 8'hF7;
    tick(8);
    n_checks++;
    if ({DIG, VLD, BLANK, DP, ERR} !== {16'h0020, 4'b0000, 4'b0010, 4'b0000, 1'b1}) begin
      n_fail++;
      $display("FAIL err_pattern got=%h/%b/%b/%b/%b exp=0020/0000/0010/0000/1", DIG, VLD, BLANK, DP, ERR);
    end
  endtask

  // Multi-select and no-select never capture, even with a bad pattern
  task automatic test_invalid_select();
    do_reset();
    LED = 8'hF7;
    SA  = 4'b1100;
    tick(50);
    SA  = 4'b1111;
    tick(50);
    n_checks++;
    if ({DIG, VLD, ERR} !== 21'h0 || state_dbg !== 2'd0) begin
      n_fail++;
      $display("FAIL invalid_select got=%h/%b/%b/%0d exp=0000/0000/0/0", DIG, VLD, ERR, state_dbg);
    end
  endtask

  // Digit 2 stops being refreshed: VLD drops after TIMEOUT, value kept
  task automatic test_timeout();
    do_reset();
    SA  = 4'b1011;
    LED = 8'hF9;
    tick(10);
    n_checks++;
    if (VLD !== 4'b0100 || DIG !== 16'h0100) begin
      n_fail++;
      $display("FAIL timeout_capture got=%b/%h exp=0100/0100", VLD, DIG);
    end
    SA = 4'b1111;
    tick(TO - 20);
    n_checks++;
    if (VLD !== 4'b0100) begin
      n_fail++;
      $display("FAIL timeout_early got=%b exp=%b", VLD, 4'b0100);
    end
    tick(30);
    n_checks++;
    if (VLD !== 4'b0000 || DIG !== 16'h0100) begin
      n_fail++;
      $display("FAIL timeout_expired got=%b/%h exp=0000/0100", VLD, DIG);
    end
  endtask

  // Reset pulse in the middle of settling, then normal capture
  task automatic test_reset_mid();
    do_reset();
    SA  = 4'b0111;
    LED = 8'h88;
    tick(8);
    SA  = 4'b1110;
    LED = 8'hF7;
    tick(8);
    n_checks++;
    if (DIG !== 16'hA000 || ERR !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid_pre got=%h/%b exp=a000/1", DIG, ERR);
    end
    SA  = 4'b1101;
    LED = 8'hB0;
    tick(4);
    n_checks++;
    if (state_dbg !== 2'd1) begin
      n_fail++;
      $display("FAIL reset_mid_settling got=%0d exp=%0d", state_dbg, 1);
    end
    RST_N = 1'b0;
    tick(1);
    n_checks++;
    if ({DIG, VLD, BLANK, DP, ERR, FRAME, state_dbg} !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_mid_clear got=%h exp=%h", {DIG, VLD, BLANK, DP, ERR, FRAME, state_dbg}, 32'h0);
    end
    RST_N = 1'b1;
    tick(10);
    n_checks++;
    if ({DIG, VLD, ERR} !== {16'h0030, 4'b0010, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_mid_resume got=%h/%b/%b exp=0030/0010/0", DIG, VLD, ERR);
    end
  endtask

  // Test sequence and final report
  initial begin
    RST_N = 1'b0;
    SA    = 4'hF;
    LED   = 8'hFF;
    test_reset();
    test_latency();
    test_scan();
    test_glitch();
    test_blank_dp_err();
    test_invalid_select();
    test_timeout();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
